// File: rtl/ctrl_multicycle_rv.sv
// ----------------------------------------------------------------------------
// ctrl_multicycle_rv
//
// Multi-cycle sequencing controller for an RV32I datapath. Each instruction
// is walked through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The controller
// produces the instruction-register load, PC write/select, register-file
// write, writeback mux select and the data-memory handshake. It also counts
// retired instructions.
//
// Ports
//   iwClk          clock, rising edge
//   iwRst_n        asynchronous active-low reset
//   owFetchReq     instruction fetch request (Moore, FETCH)
//   iwFetchAck     instruction word valid this cycle
//   owIrLoad       load IR (Mealy on accepted fetch)
//   iwOpCode       opcode field (stable after DECODE)
//   iwFunct3       funct3 field
//   iwRd           rd field
//   iwBranchTaken  ALU compare result, valid in EXEC
//   owPcWrite      PC write enable (one pulse per retirement)
//   owPcSel        0 PC+4, 1 branch, 2 JAL, 3 JALR
//   owRfWrite      register-file write enable
//   owWbSel        0 ALU, 1 load data, 2 PC+4, 3 imm20<<12
//   owMemReq       data memory request (Moore, MEM)
//   owMemWe        data memory write (Moore, MEM of a store)
//   iwMemAck       data memory access complete
//   owIllegal      sticky illegal-instruction flag (TRAP until reset)
//   owState        current state, debug
//   owInstret      retired-instruction counter, wraps
// ----------------------------------------------------------------------------
module ctrl_multicycle_rv #(
  parameter int INSTRET_W = 32
) (
  input  logic                 iwClk,
  input  logic                 iwRst_n,
  output logic                 owFetchReq,
  input  logic                 iwFetchAck,
  output logic                 owIrLoad,
  input  logic [6:0]           iwOpCode,
  input  logic [2:0]           iwFunct3,
  input  logic [4:0]           iwRd,
  input  logic                 iwBranchTaken,
  output logic                 owPcWrite,
  output logic [1:0]           owPcSel,
  output logic                 owRfWrite,
  output logic [1:0]           owWbSel,
  output logic                 owMemReq,
  output logic                 owMemWe,
  input  logic                 iwMemAck,
  output logic                 owIllegal,
  output logic [2:0]           owState,
  output logic [INSTRET_W-1:0] owInstret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  // Instruction classes captured in DECODE.
  localparam logic [3:0] C_NONE    = 4'd0;
  localparam logic [3:0] C_LUI     = 4'd1;
  localparam logic [3:0] C_AUIPC   = 4'd2;
  localparam logic [3:0] C_JAL     = 4'd3;
  localparam logic [3:0] C_JALR    = 4'd4;
  localparam logic [3:0] C_BRANCH  = 4'd5;
  localparam logic [3:0] C_LOAD    = 4'd6;
  localparam logic [3:0] C_STORE   = 4'd7;
  localparam logic [3:0] C_OPIMM   = 4'd8;
  localparam logic [3:0] C_OP      = 4'd9;
  localparam logic [3:0] C_FENCE   = 4'd10;
  localparam logic [3:0] C_ILLEGAL = 4'd11;

  logic [2:0]           r_state;
  logic [2:0]           w_state_next;
  logic [3:0]           r_class;
  logic [3:0]           w_class_dec;
  logic [INSTRET_W-1:0] r_instret;

  logic       w_fetch_req;
  logic       w_ir_load;
  logic       w_pc_write;
  logic [1:0] w_pc_sel;
  logic       w_rf_write;
  logic [1:0] w_wb_sel;
  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_illegal;

  // Opcode classification; consumed only while in DECODE.
  always_comb begin
    w_class_dec = C_ILLEGAL;
    case (iwOpCode)
      7'b0110111: w_class_dec = C_LUI;
      7'b0010111: w_class_dec = C_AUIPC;
      7'b1101111: w_class_dec = C_JAL;
      7'b1100111: w_class_dec = (iwFunct3 == 3'b000) ? C_JALR : C_ILLEGAL;
      7'b1100011: w_class_dec = (iwFunct3[2:1] == 2'b01) ? C_ILLEGAL : C_BRANCH;
      7'b0000011: w_class_dec = C_LOAD;
      7'b0100011: w_class_dec = C_STORE;
      7'b0010011: w_class_dec = C_OPIMM;
      7'b0110011: w_class_dec = C_OP;
      7'b0001111: w_class_dec = C_FENCE;
      default:    w_class_dec = C_ILLEGAL;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_fetch_req  = 1'b0;
    w_ir_load    = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_sel     = 2'd0;
    w_rf_write   = 1'b0;
    w_wb_sel     = 2'd0;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_fetch_req = 1'b1;
        if (iwFetchAck) begin
          w_ir_load    = 1'b1;
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        w_state_next = (w_class_dec == C_ILLEGAL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        case (r_class)
          C_LOAD, C_STORE: w_state_next = S_MEM;
          C_BRANCH: begin
            w_pc_write   = 1'b1;
            w_pc_sel     = iwBranchTaken ? 2'd1 : 2'd0;
            w_state_next = S_FETCH;
          end
          C_FENCE: begin
            w_pc_write   = 1'b1;
            w_state_next = S_FETCH;
          end
          C_OP, C_OPIMM, C_LUI, C_AUIPC, C_JAL, C_JALR: w_state_next = S_WB;
          // Unreachable: DECODE never lets an illegal class into EXEC.
          default: w_state_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (r_class == C_STORE);
        if (iwMemAck) begin
          if (r_class == C_STORE) begin
            // Stores retire straight out of MEM; no register result.
            w_pc_write   = 1'b1;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_WB;
          end
        end
      end
      S_WB: begin
        w_rf_write   = (iwRd != 5'd0);
        w_pc_write   = 1'b1;
        w_state_next = S_FETCH;
        case (r_class)
          C_LOAD:         w_wb_sel = 2'd1;
          C_JAL, C_JALR:  w_wb_sel = 2'd2;
          C_LUI:          w_wb_sel = 2'd3;
          default:        w_wb_sel = 2'd0;
        endcase
        case (r_class)
          C_JAL:   w_pc_sel = 2'd2;
          C_JALR:  w_pc_sel = 2'd3;
          default: w_pc_sel = 2'd0;
        endcase
      end
      S_TRAP: begin
        w_illegal = 1'b1;
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge iwClk or negedge iwRst_n) begin
    if (!iwRst_n) begin
      r_state   <= S_FETCH;
      r_class   <= C_NONE;
      r_instret <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_DECODE) begin
        r_class <= w_class_dec;
      end
      if (w_pc_write) begin
        r_instret <= r_instret + INSTRET_W'(1);
      end
    end
  end

  // Reset state is FETCH, so the fetch request (and the Mealy IR load)
  // must be masked while reset is held to keep every output at 0.
  assign owFetchReq = iwRst_n & w_fetch_req;
  assign owIrLoad   = iwRst_n & w_ir_load;
  assign owPcWrite  = iwRst_n & w_pc_write;
  assign owPcSel    = iwRst_n ? w_pc_sel : 2'd0;
  assign owRfWrite  = iwRst_n & w_rf_write;
  assign owWbSel    = iwRst_n ? w_wb_sel : 2'd0;
  assign owMemReq   = iwRst_n & w_mem_req;
  assign owMemWe    = iwRst_n & w_mem_we;
  assign owIllegal  = iwRst_n & w_illegal;
  assign owState    = iwRst_n ? r_state : 3'd0;
  assign owInstret  = r_instret;

endmodule
